// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a 1-deep command-echo buffer and a
// 12-byte telemetry frame generator (on-demand or periodic), round-robin arbitrated.
module uart_tx_scheduler #(
   parameter int REPORT_PERIOD = 50000000,
   parameter int ACK_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        echo_valid,
   input  logic [7:0]  echo_data,
   output logic        echo_ready,
   input  logic        report_req,
   input  logic        auto_en,
   input  logic [15:0] solar_th,
   input  logic [63:0] th_pack,
   input  logic        idle_ready_tx,
   output logic        start_tx,
   output logic [7:0]  data_tx,
   output logic        busy,
   output logic [7:0]  frames_sent
);

   localparam int TW = $clog2(REPORT_PERIOD);
   localparam int AW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_PERIOD - 1);
   localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;
   typedef enum logic {SRC_ECHO, SRC_REPORT} src_t;

   state_t        state;
   src_t          src;
   src_t          last_grant;
   logic          echo_full;
   logic [7:0]    echo_buf;
   logic          pending;
   logic [TW-1:0] timer;
   logic [AW-1:0] ack_cnt;
   logic [3:0]    idx;
   logic [15:0]   snap_solar;
   logic [63:0]   snap_pack;
   logic          tick;
   logic          grant_echo;
   logic          grant_frame;

   function automatic logic [7:0] frame_checksum(input logic [15:0] s, input logic [63:0] p);
      logic [7:0] cs;
      cs = s[15:8] ^ s[7:0];
      for (int i = 0; i < 8; i++) cs = cs ^ p[8*i +: 8];
      return cs;
   endfunction

   function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [15:0] s,
                                             input logic [63:0] p);
      logic [7:0] b;
      case (i)
         4'd0:    b = 8'h54;
         4'd1:    b = s[15:8];
         4'd2:    b = s[7:0];
         4'd3:    b = p[63:56];
         4'd4:    b = p[55:48];
         4'd5:    b = p[47:40];
         4'd6:    b = p[39:32];
         4'd7:    b = p[31:24];
         4'd8:    b = p[23:16];
         4'd9:    b = p[15:8];
         4'd10:   b = p[7:0];
         default: b = frame_checksum(s, p);
      endcase
      return b;
   endfunction

   assign tick       = auto_en && (timer == TIMER_LAST);
   assign echo_ready = !echo_full;
   assign busy       = (state != IDLE);

   always_comb begin
      grant_echo  = 1'b0;
      grant_frame = 1'b0;
      if (state == IDLE && idle_ready_tx) begin
         if (echo_full && pending) begin
            if (last_grant == SRC_REPORT) grant_echo = 1'b1;
            else                          grant_frame = 1'b1;
         end else if (echo_full) begin
            grant_echo = 1'b1;
         end else if (pending) begin
            grant_frame = 1'b1;
         end
      end
   end

   // Payload registers carry no reset; they are only read after being loaded.
   always_ff @(posedge clk) begin
      if (grant_frame) begin
         snap_solar <= solar_th;
         snap_pack  <= th_pack;
      end
      if (echo_valid && !echo_full) echo_buf <= echo_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         src         <= SRC_ECHO;
         last_grant  <= SRC_REPORT;
         echo_full   <= 1'b0;
         pending     <= 1'b0;
         timer       <= '0;
         ack_cnt     <= '0;
         idx         <= 4'd0;
         start_tx    <= 1'b0;
         data_tx     <= 8'h00;
         frames_sent <= 8'h00;
      end else begin
         if (!auto_en || tick) timer <= '0;
         else                  timer <= timer + 1'b1;

         // A request landing on the grant cycle keeps pending set for one more frame.
         pending <= (pending && !grant_frame) || report_req || tick;

         if (echo_valid && !echo_full) echo_full <= 1'b1;

         start_tx <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_echo) begin
                  src        <= SRC_ECHO;
                  last_grant <= SRC_ECHO;
                  data_tx    <= echo_buf;
                  start_tx   <= 1'b1;
                  state      <= SEND;
               end else if (grant_frame) begin
                  src        <= SRC_REPORT;
                  last_grant <= SRC_REPORT;
                  idx        <= 4'd0;
                  data_tx    <= 8'h54;
                  start_tx   <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               ack_cnt <= '0;
               state   <= WAIT_LOW;
               if (src == SRC_ECHO) echo_full <= 1'b0;
            end
            WAIT_LOW: begin
               // A UART that never acknowledges is assumed to have taken the byte.
               if (!idle_ready_tx || ack_cnt == ACK_LAST) state <= WAIT_HIGH;
               else                                       ack_cnt <= ack_cnt + 1'b1;
            end
            WAIT_HIGH: begin
               if (idle_ready_tx) begin
                  if (src == SRC_REPORT && idx != 4'd11) begin
                     idx      <= idx + 4'd1;
                     data_tx  <= frame_byte(idx + 4'd1, snap_solar, snap_pack);
                     start_tx <= 1'b1;
                     state    <= SEND;
                  end else begin
                     if (src == SRC_REPORT) frames_sent <= frames_sent + 8'd1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Owns the single UART transmitter and shares it between two requesters.
- Requester 1 is the command-echo path: single bytes from the RX command decoder.
- Requester 2 is the telemetry reporter: fixed 12-byte frames carrying a snapshot of all threshold registers, triggered on demand or by an internal period timer.
- Sits between the threshold/command controller and the UART's start_tx/data_tx/idle_ready_tx handshake.

Parameters:
- REPORT_PERIOD, 50000000: clock cycles between automatic report triggers while auto_en=1 (must be >=2).
- ACK_TIMEOUT, 255: maximum cycles spent waiting for idle_ready_tx to drop after a start pulse.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- echo_valid  in  1  echo byte offered
- echo_data  in  8  echo byte
- echo_ready  out  1  1 = echo holding register empty
- report_req  in  1  request one telemetry frame; level or pulse, sampled every cycle
- auto_en  in  1  enables the periodic report timer
- solar_th  in  16  solar threshold, unsigned
- th_pack  in  64  eight signed 8-bit thresholds, [63:56] solar_cooldown down to [7:0] geothermal_heatup (order: solar_cool, solar_heat, gh_cool, gh_heat, amb_cool, amb_heat, geo_cool, geo_heat)
- idle_ready_tx  in  1  UART transmitter idle
- start_tx  out  1  one-cycle start pulse to the UART
- data_tx  out  8  byte to transmit
- busy  out  1  FSM not in IDLE
- frames_sent  out  8  count of completed frames, wraps 255->0

Behaviour:
- Reset (rst=0, async) values:
  - outputs: start_tx=0, data_tx=0x00, echo_ready=1, busy=0, frames_sent=0.
  - internal: pending=0, timer=0, last_grant=REPORT, FSM=IDLE.
- Echo buffer:
  - 1-deep; loads on echo_valid && echo_ready. echo_ready falls the next cycle.
  - Freed (echo_ready=1) the cycle after its byte's start_tx pulse.
- Pending flag:
  - Set by report_req=1 or a timer tick; cleared when a frame is granted.
  - A set and a grant in the same cycle leave pending=1.
  - Multiple requests before a grant collapse into one frame.
- Timer:
  - auto_en=0 holds the timer at 0.
  - Otherwise it counts 0..REPORT_PERIOD-1; the wrap cycle is a tick.
- Arbitration: evaluated only in IDLE with idle_ready_tx=1.
  - If both requesters are waiting, grant the one not in last_grant (round-robin), then update last_grant.
  - A frame, once granted, is atomic: no echo bytes are interleaved.
- Frame content:
  - byte0 = 0x54 ("T"); byte1 = solar_th[15:8]; byte2 = solar_th[7:0]; bytes3..10 = th_pack[63:56] .. th_pack[7:0].
  - byte11 = XOR of bytes 1..10.
  - solar_th and th_pack are snapshotted into registers on the grant cycle; later input changes do not affect the frame in flight.
- FSM states: IDLE, SEND, WAIT_LOW, WAIT_HIGH.
  - IDLE -> SEND on grant; byte index is set to 0 for a frame, or the echo source is selected.
  - SEND: start_tx=1 for exactly one cycle. data_tx is driven the same cycle and held stable until the next SEND. Next state is WAIT_LOW.
  - WAIT_LOW -> WAIT_HIGH when idle_ready_tx=0, or after ACK_TIMEOUT cycles (timeout treated as already sent).
  - WAIT_HIGH -> on idle_ready_tx=1:
    - frame with index<11: increment the index, go to SEND.
    - frame with index=11: frames_sent+1, go to IDLE.
    - echo: go to IDLE.
- Latency: from IDLE with the UART idle, a grant registers on the request cycle+1, and start_tx is asserted on the next cycle.
- Async reset mid-frame aborts the frame immediately. No partial completion; frames_sent is not incremented.

Test Plan:
- Single echo: echo_valid with 0x77 ("w"), UART model idle, busy 10 cycles per byte -> exactly one start_tx with data_tx=0x77; echo_ready back to 1 after the pulse.
- Frame with defaults: solar_th=2550, th_pack=0x2310231023102310, report_req pulse -> 12 pulses with bytes 54 09 F6 23 10 23 10 23 10 23 10 FF; frames_sent=1.
- Collision: report_req and echo_valid(0x41) in the same IDLE cycle, last_grant=REPORT -> echo 0x41 first, then the full frame. A second echo arriving mid-frame waits until after byte11.
- Snapshot: change solar_th to 100 during byte 4 -> frame still carries 09 F6. report_req held high throughout -> exactly one extra frame afterwards.
- Auto timer: REPORT_PERIOD=20, auto_en=1 -> frames start every 20 cycles or when the previous frame completes, whichever is later. auto_en=0 -> no new frames.
- Timeout/reset: idle_ready_tx stuck at 1, ACK_TIMEOUT=4 -> frame still completes with 12 pulses. rst=0 during byte 5 -> all outputs at reset values without waiting for a clock edge.
